// File: rtl/sd_cmd_resp_rx.sv
// SD command-channel response receiver: deserializes 48-bit or 136-bit (R2) card responses,
// recomputes CRC7, checks the transmission and end bits, and enforces a start-bit timeout.
module sd_cmd_resp_rx #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START_RX,
  input  logic         LONG_RSP,
  input  logic         CMD_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [5:0]   RSP_INDEX,
  output logic [127:0] RSP_DATA,
  output logic         CRC_ERR,
  output logic         FRAME_ERR,
  output logic         TIMEOUT
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECV} state_t;

  state_t          state_q, state_d;
  logic            long_q;
  logic [TW-1:0]   tcnt_q;
  logic [7:0]      bcnt_q;
  logic [6:0]      crc_q;
  logic [132:0]    sr_q;
  logic            accept, start_hit, tmo_hit, end_hit, covered;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic inv;
    inv = b ^ c[6];
    return {c[5:3], c[2] ^ inv, c[1:0], inv};
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    start_hit = 1'b0;
    tmo_hit   = 1'b0;
    end_hit   = 1'b0;
    covered   = long_q ? (bcnt_q >= 8'd8 && bcnt_q <= 8'd127) : (bcnt_q <= 8'd39);
    case (state_q)
      IDLE: begin
        if (START_RX) begin
          accept  = 1'b1;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!CMD_IN) begin
          start_hit = 1'b1;
          state_d   = RECV;
        end else if (tcnt_q == TW'(RESP_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      RECV: begin
        if (bcnt_q == (long_q ? 8'd135 : 8'd47)) begin
          end_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      long_q    <= 1'b0;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      crc_q     <= '0;
      DONE      <= 1'b0;
      CRC_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;
      RSP_INDEX <= '0;
      RSP_DATA  <= '0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        long_q    <= LONG_RSP;
        CRC_ERR   <= 1'b0;
        FRAME_ERR <= 1'b0;
        TIMEOUT   <= 1'b0;
        crc_q     <= '0;
        tcnt_q    <= '0;
      end
      if (state_q == WAIT_START) begin
        if (start_hit) begin
          bcnt_q <= 8'd1;
          if (!long_q) crc_q <= crc7_step(crc_q, CMD_IN);
        end else if (tmo_hit) begin
          TIMEOUT <= 1'b1;
          DONE    <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end
      if (state_q == RECV) begin
        bcnt_q <= bcnt_q + 8'd1;
        if (covered) crc_q <= crc7_step(crc_q, CMD_IN);
        if (bcnt_q == 8'd1 && CMD_IN) FRAME_ERR <= 1'b1;
        // sr_q holds frame bits 2..end-1 with the last received bit at [0]
        if (end_hit) begin
          DONE      <= 1'b1;
          CRC_ERR   <= (crc_q != sr_q[6:0]);
          if (!CMD_IN) FRAME_ERR <= 1'b1;
          RSP_INDEX <= long_q ? sr_q[132:127] : sr_q[44:39];
          RSP_DATA  <= long_q ? {sr_q[126:0], 1'b0} : {96'd0, sr_q[38:7]};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == RECV && !end_hit) sr_q <= {sr_q[131:0], CMD_IN};
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Bench for sd_cmd_resp_rx: frames are built from fields, CRC7 is computed by polynomial
// long division, and decoded outputs and DONE timing are compared against that model.
module tb_sd_cmd_resp_rx;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START_RX = 1'b0;
  logic         LONG_RSP = 1'b0;
  logic         CMD_IN = 1'b1;
  logic         BUSY, DONE, CRC_ERR, FRAME_ERR, TIMEOUT;
  logic [5:0]   RSP_INDEX;
  logic [127:0] RSP_DATA;

  int passed = 0;
  int total  = 0;

  logic         fbits [0:135];
  logic [5:0]   exp_index;
  logic [127:0] exp_data;
  logic         exp_crc_err, exp_frame_err;

  sd_cmd_resp_rx #(.RESP_TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .START_RX(START_RX), .LONG_RSP(LONG_RSP), .CMD_IN(CMD_IN),
    .BUSY(BUSY), .DONE(DONE), .RSP_INDEX(RSP_INDEX), .RSP_DATA(RSP_DATA),
    .CRC_ERR(CRC_ERR), .FRAME_ERR(FRAME_ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 over frame bits [from..to].
  function automatic logic [6:0] ref_crc(input int from, input int to);
    logic d[$];
    logic [7:0] poly;
    logic [6:0] r;
    poly = 8'b1000_1001;
    for (int i = from; i <= to; i++) d.push_back(fbits[i]);
    repeat (7) d.push_back(1'b0);
    for (int i = 0; i + 7 < d.size(); i++)
      if (d[i]) for (int j = 0; j < 8; j++) d[i+j] = d[i+j] ^ poly[7-j];
    r = '0;
    for (int j = 0; j < 7; j++) r = {r[5:0], d[d.size()-7+j]};
    return r;
  endfunction

  task automatic build_short(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] c;
    fbits[0] = 1'b0;
    fbits[1] = 1'b0;
    for (int i = 0; i < 6; i++)  fbits[2+i] = idx[5-i];
    for (int i = 0; i < 32; i++) fbits[8+i] = arg[31-i];
    c = ref_crc(0, 39);
    for (int i = 0; i < 7; i++)  fbits[40+i] = c[6-i];
    fbits[47] = 1'b1;
  endtask

  task automatic build_long(input logic [119:0] p);
    logic [6:0] c;
    fbits[0] = 1'b0;
    fbits[1] = 1'b0;
    for (int i = 2; i < 8; i++)   fbits[i] = 1'b1;
    for (int i = 0; i < 120; i++) fbits[8+i] = p[119-i];
    c = ref_crc(8, 127);
    for (int i = 0; i < 7; i++)   fbits[128+i] = c[6-i];
    fbits[135] = 1'b1;
  endtask

  task automatic model(input logic longr, input int n);
    logic [6:0] rx, c;
    exp_index = '0;
    for (int i = 2; i <= 7; i++) exp_index = {exp_index[4:0], fbits[i]};
    exp_data = '0;
    if (longr) begin
      for (int i = 8; i <= 134; i++) exp_data = {exp_data[126:0], fbits[i]};
      exp_data = {exp_data[126:0], 1'b0};
      c = ref_crc(8, 127);
    end else begin
      for (int i = 8; i <= 39; i++) exp_data = {exp_data[126:0], fbits[i]};
      c = ref_crc(0, 39);
    end
    rx = '0;
    for (int i = n - 8; i <= n - 2; i++) rx = {rx[5:0], fbits[i]};
    exp_crc_err   = (c != rx);
    exp_frame_err = fbits[1] | ~fbits[n-1];
  endtask

  // Arms the receiver, idles gap high samples, then sends n frame bits; reports the edge
  // (counted from the START_RX edge) at which DONE was first seen, or -1.
  task automatic drive_frame(input logic longr, input int gap, input int n,
                             input int pulse_at, output int done_at);
    done_at  = -1;
    START_RX = 1'b1;
    LONG_RSP = longr;
    tick();
    START_RX = 1'b0;
    LONG_RSP = 1'($urandom_range(0, 1));
    for (int i = 0; i < gap + n; i++) begin
      if (i < gap) CMD_IN = 1'b1;
      else         CMD_IN = fbits[i-gap];
      if (i == gap + pulse_at) begin
        START_RX = 1'b1;
        LONG_RSP = ~longr;
      end
      tick();
      START_RX = 1'b0;
      if (DONE && done_at < 0) done_at = i + 1;
    end
    CMD_IN = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({BUSY, DONE, CRC_ERR, FRAME_ERR, TIMEOUT} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {BUSY, DONE, CRC_ERR, FRAME_ERR, TIMEOUT});
    else passed++;
    total++;
    if (RSP_INDEX !== 6'd0) $display("FAIL reset_index got %h want 0", RSP_INDEX);
    else passed++;
    total++;
    if (RSP_DATA !== 128'd0) $display("FAIL reset_data got %h want 0", RSP_DATA);
    else passed++;
    #2 RST = 1'b0;
    tick();
  endtask

  task automatic test_short_basic();
    int d;
    build_short(6'd17, 32'h0000_0900);
    drive_frame(1'b0, 5, 48, -1, d);
    total++;
    if (d !== 53) $display("FAIL short_latency got %0d want 53", d); else passed++;
    total++;
    if ({BUSY, CRC_ERR, FRAME_ERR, TIMEOUT} !== 4'b0)
      $display("FAIL short_flags got %b want 0000", {BUSY, CRC_ERR, FRAME_ERR, TIMEOUT});
    else passed++;
    total++;
    if (RSP_INDEX !== 6'd17) $display("FAIL short_index got %0d want 17", RSP_INDEX); else passed++;
    total++;
    if (RSP_DATA !== 128'h900) $display("FAIL short_data got %h want 900", RSP_DATA); else passed++;
    tick();
    total++;
    if (DONE !== 1'b0) $display("FAIL done_pulse got %b want 0", DONE); else passed++;
  endtask

  task automatic test_cmd0_frame();
    int d;
    logic [47:0] v;
    v = 48'h40_0000_0000_95;
    for (int i = 0; i < 48; i++) fbits[i] = v[47-i];
    drive_frame(1'b0, 2, 48, -1, d);
    total++;
    if ({d == 50, CRC_ERR, FRAME_ERR, RSP_INDEX} !== {1'b1, 1'b0, 1'b1, 6'd0})
      $display("FAIL cmd0_frame got done_at=%0d crc=%b frame=%b idx=%0d want 50 0 1 0",
               d, CRC_ERR, FRAME_ERR, RSP_INDEX);
    else passed++;
  endtask

  task automatic test_crc_err();
    int d;
    build_short(6'($urandom), $urandom);
    fbits[39] = ~fbits[39];
    drive_frame(1'b0, 1, 48, -1, d);
    total++;
    if ({d == 49, CRC_ERR, FRAME_ERR} !== 3'b110)
      $display("FAIL crc_flip got done_at=%0d crc=%b frame=%b want 49 1 0", d, CRC_ERR, FRAME_ERR);
    else passed++;
    build_short(6'($urandom), $urandom);
    fbits[47] = 1'b0;
    drive_frame(1'b0, 0, 48, -1, d);
    total++;
    if ({d == 48, CRC_ERR, FRAME_ERR} !== 3'b101)
      $display("FAIL end_bit got done_at=%0d crc=%b frame=%b want 48 0 1", d, CRC_ERR, FRAME_ERR);
    else passed++;
    CMD_IN = 1'b1;
    tick();
  endtask

  task automatic test_long();
    int d, gap;
    logic [119:0] p;
    p   = 120'h0123456789ABCDEF0123456789ABEF;
    gap = $urandom_range(0, 20);
    build_long(p);
    model(1'b1, 136);
    drive_frame(1'b1, gap, 136, -1, d);
    total++;
    if (d !== gap + 136) $display("FAIL long_latency got %0d want %0d", d, gap + 136); else passed++;
    total++;
    if (RSP_DATA[127:8] !== p || RSP_DATA !== exp_data)
      $display("FAIL long_data got %h want %h", RSP_DATA, exp_data);
    else passed++;
    total++;
    if ({RSP_INDEX, CRC_ERR, FRAME_ERR, TIMEOUT} !== {6'h3F, 3'b000})
      $display("FAIL long_status got idx=%h flags=%b want 3f 000", RSP_INDEX, {CRC_ERR, FRAME_ERR, TIMEOUT});
    else passed++;
  endtask

  task automatic test_timeout();
    int d;
    d = -1;
    START_RX = 1'b1;
    tick();
    START_RX = 1'b0;
    CMD_IN   = 1'b1;
    total++;
    if (BUSY !== 1'b1) $display("FAIL busy_after_start got %b want 1", BUSY); else passed++;
    for (int i = 1; i <= 200 && d < 0; i++) begin
      tick();
      if (DONE) d = i;
    end
    total++;
    if ({d == 64, TIMEOUT, BUSY, CRC_ERR, FRAME_ERR} !== 5'b11000)
      $display("FAIL timeout got done_at=%0d to=%b busy=%b want 64 1 0", d, TIMEOUT, BUSY);
    else passed++;
    build_short(6'd5, 32'hCAFE_F00D);
    model(1'b0, 48);
    drive_frame(1'b0, 63, 48, -1, d);
    total++;
    if ({d == 111, TIMEOUT, CRC_ERR, FRAME_ERR} !== 4'b1000)
      $display("FAIL late_start got done_at=%0d to=%b crc=%b frame=%b want 111 0 0 0",
               d, TIMEOUT, CRC_ERR, FRAME_ERR);
    else passed++;
    total++;
    if ({RSP_INDEX, RSP_DATA} !== {exp_index, exp_data})
      $display("FAIL late_start_data got %h/%h want %h/%h", RSP_INDEX, RSP_DATA, exp_index, exp_data);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int d, seen;
    seen = 0;
    build_short(6'd33, 32'h1234_5678);
    START_RX = 1'b1;
    tick();
    START_RX = 1'b0;
    for (int i = 0; i < 3 + 20; i++) begin
      CMD_IN = (i < 3) ? 1'b1 : fbits[i-3];
      tick();
    end
    RST = 1'b1;
    #1;
    total++;
    if ({BUSY, DONE, CRC_ERR, FRAME_ERR, TIMEOUT, RSP_INDEX, RSP_DATA} !== '0)
      $display("FAIL midframe_reset got busy=%b done=%b idx=%h data=%h want all 0",
               BUSY, DONE, RSP_INDEX, RSP_DATA);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      CMD_IN = 1'($urandom);
      tick();
      if (DONE) seen++;
    end
    RST    = 1'b0;
    CMD_IN = 1'b1;
    repeat (4) begin
      tick();
      if (DONE) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL reset_no_done got %0d pulses want 0", seen); else passed++;
    model(1'b0, 48);
    drive_frame(1'b0, 4, 48, 20, d);
    total++;
    if ({d == 52, RSP_INDEX, RSP_DATA, CRC_ERR, FRAME_ERR} !== {1'b1, exp_index, exp_data, 2'b00})
      $display("FAIL after_reset got done_at=%0d idx=%h data=%h want 52 %h %h",
               d, RSP_INDEX, RSP_DATA, exp_index, exp_data);
    else passed++;
  endtask

  // Frames follow each other with START_RX raised in the DONE cycle.
  task automatic test_back_to_back();
    int d, gap, n, mode, pos;
    logic longr;
    for (int f = 0; f < 10; f++) begin
      longr = 1'($urandom_range(0, 1));
      n     = longr ? 136 : 48;
      gap   = $urandom_range(0, 63);
      if (longr) build_long({$urandom, $urandom, $urandom, $urandom});
      else       build_short(6'($urandom), $urandom);
      mode = $urandom_range(0, 3);
      pos  = $urandom_range(1, n - 1);
      if (mode == 1) fbits[pos] = ~fbits[pos];
      if (mode == 2) fbits[n-1] = 1'b0;
      if (mode == 3) fbits[1]   = 1'b1;
      model(longr, n);
      drive_frame(longr, gap, n, (f % 3 == 0) ? 10 : -1, d);
      total++;
      if (d !== gap + n) $display("FAIL b2b_latency[%0d] got %0d want %0d", f, d, gap + n);
      else passed++;
      total++;
      if ({CRC_ERR, FRAME_ERR, TIMEOUT, BUSY} !== {exp_crc_err, exp_frame_err, 2'b00})
        $display("FAIL b2b_flags[%0d] got %b want %b", f, {CRC_ERR, FRAME_ERR, TIMEOUT, BUSY},
                 {exp_crc_err, exp_frame_err, 2'b00});
      else passed++;
      total++;
      if ({RSP_INDEX, RSP_DATA} !== {exp_index, exp_data})
        $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", f, RSP_INDEX, RSP_DATA, exp_index, exp_data);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_short_basic();
    test_cmd0_frame();
    test_crc_err();
    test_long();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
